// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with load-data formatting, write-back source mux
// and retired-instruction counter, feeding the register-file write port.
module mem_wb_writeback #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_reg_write,
    input  logic [4:0]       in_rd,
    input  logic [1:0]       in_wb_sel,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_mem_rdata,
    input  logic [XLEN-1:0]  in_pc_plus4,
    input  logic [XLEN-1:0]  in_imm,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  write_data,
    output logic             reg_write,
    output logic             wb_valid,
    output logic [CNT_W-1:0] instret
);

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    logic             valid_q, valid_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       rd_q, rd_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [XLEN-1:0]  load_data;
    logic             retire;

    // Load lane extraction; addr_lo[0] is irrelevant for halfword loads.
    always_comb begin
        ld_byte = in_mem_rdata[7:0];
        case (in_addr_lo)
            2'd0:    ld_byte = in_mem_rdata[7:0];
            2'd1:    ld_byte = in_mem_rdata[15:8];
            2'd2:    ld_byte = in_mem_rdata[23:16];
            default: ld_byte = in_mem_rdata[31:24];
        endcase
        ld_half = in_addr_lo[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];

        load_data = in_mem_rdata;
        case (in_funct3)
            3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
            default: load_data = in_mem_rdata;
        endcase
    end

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        wdata_d     = wdata_q;

        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (!stall) begin
            valid_d     = in_valid;
            reg_write_d = in_reg_write;
            rd_d        = in_rd;
            case (in_wb_sel)
                WB_ALU:  wdata_d = in_alu_result;
                WB_LOAD: wdata_d = load_data;
                WB_PC4:  wdata_d = in_pc_plus4;
                default: wdata_d = in_imm;
            endcase
        end

        // The WB instruction retires when it leaves the stage, so a stalled
        // instruction counts once and a flushed-out one still counts.
        retire    = valid_q & (~stall | flush);
        instret_d = instret_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            wdata_q     <= '0;
            instret_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
            instret_q   <= instret_d;
        end
    end

    assign rd         = rd_q;
    assign write_data = wdata_q;
    assign reg_write  = valid_q & reg_write_q & (rd_q != 5'd0);
    assign wb_valid   = valid_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback: reset, load formatting, source mux,
// x0 suppression, stall/flush priority and counter wrap.
module tb_mem_wb_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush;
    logic        in_valid, in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4, in_imm;

    logic [4:0]  rd, rd4;
    logic [31:0] write_data, write_data4;
    logic        reg_write, wb_valid, reg_write4, wb_valid4;
    logic [63:0] instret;
    logic [3:0]  instret4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_writeback dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
        .in_pc_plus4(in_pc_plus4), .in_imm(in_imm),
        .rd(rd), .write_data(write_data), .reg_write(reg_write),
        .wb_valid(wb_valid), .instret(instret)
    );

    mem_wb_writeback #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
        .in_pc_plus4(in_pc_plus4), .in_imm(in_imm),
        .rd(rd4), .write_data(write_data4), .reg_write(reg_write4),
        .wb_valid(wb_valid4), .instret(instret4)
    );

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] r,
                         input logic [1:0] sel, input logic [2:0] f3,
                         input logic [1:0] alo, input logic [31:0] alu,
                         input logic [31:0] mdata, input logic [31:0] pc4,
                         input logic [31:0] imm);
        in_valid = v; in_reg_write = rw; in_rd = r; in_wb_sel = sel;
        in_funct3 = f3; in_addr_lo = alo; in_alu_result = alu;
        in_mem_rdata = mdata; in_pc_plus4 = pc4; in_imm = imm;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", rd); end
        checks++; if (write_data !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", write_data); end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b want 0", reg_write); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wbvalid got %b want 0", wb_valid); end
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret got %0d want 0", instret); end

        // Reset between edges with a live write in WB.
        drive(1'b1, 1'b1, 5'd1, 2'b00, 3'b000, 2'd0, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0);
        tick();
        checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL midreset_pre_regwrite got %b want 1", reg_write); end
        #2 reset = 1'b1;
        #1;
        checks++; if (rd !== 5'd0) begin errors++; $display("FAIL midreset_rd got %0d want 0", rd); end
        checks++; if (write_data !== 32'h0) begin errors++; $display("FAIL midreset_wdata got %h want 0", write_data); end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL midreset_regwrite got %b want 0", reg_write); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL midreset_wbvalid got %b want 0", wb_valid); end
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL midreset_instret got %0d want 0", instret); end
        #1 reset = 1'b0;
        idle();
        tick();
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL postreset_instret got %0d want 0", instret); end
    endtask

    task automatic test_load_format();
        logic [2:0]  f3_t  [9] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b010, 3'b011, 3'b001, 3'b001};
        logic [1:0]  alo_t [9] = '{2'd3,   2'd3,   2'd1,   2'd2,   2'd2,   2'd0,   2'd2,   2'd3,   2'd0};
        logic [31:0] exp_t [9] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'hFFFF80FF,
                                   32'h000080FF, 32'h80FF7F01, 32'h80FF7F01, 32'hFFFF80FF,
                                   32'h00007F01};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 5'd7, 2'b01, f3_t[i], alo_t[i], 32'h11111111,
                  32'h80FF7F01, 32'h22222222, 32'h33333333);
            tick();
            checks++;
            if (write_data !== exp_t[i]) begin
                errors++;
                $display("FAIL load_%0d funct3=%b addr_lo=%0d got %h want %h",
                         i, f3_t[i], alo_t[i], write_data, exp_t[i]);
            end
        end
    endtask

    task automatic test_source_mux();
        drive(1'b1, 1'b1, 5'd1, 2'b00, 3'b010, 2'd0, 32'hDEADBEEF, 32'h0, 32'h4, 32'h5);
        tick();
        checks++; if (rd !== 5'd1) begin errors++; $display("FAIL mux_alu_rd got %0d want 1", rd); end
        checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL mux_alu_wdata got %h want deadbeef", write_data); end
        checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL mux_alu_regwrite got %b want 1", reg_write); end
        drive(1'b1, 1'b1, 5'd2, 2'b10, 3'b010, 2'd0, 32'hDEADBEEF, 32'h0, 32'h00000008, 32'h5);
        tick();
        checks++; if (rd !== 5'd2) begin errors++; $display("FAIL mux_pc4_rd got %0d want 2", rd); end
        checks++; if (write_data !== 32'h00000008) begin errors++; $display("FAIL mux_pc4_wdata got %h want 00000008", write_data); end
        drive(1'b1, 1'b1, 5'd2, 2'b11, 3'b010, 2'd0, 32'hDEADBEEF, 32'h0, 32'h00000008, 32'hCAFEB000);
        tick();
        checks++; if (write_data !== 32'hCAFEB000) begin errors++; $display("FAIL mux_imm_wdata got %h want cafeb000", write_data); end
        checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL mux_imm_regwrite got %b want 1", reg_write); end
    endtask

    task automatic test_x0_write();
        do_reset();
        drive(1'b1, 1'b1, 5'd0, 2'b00, 3'b010, 2'd0, 32'h12345678, 32'h0, 32'h0, 32'h0);
        tick();
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL x0_regwrite got %b want 0", reg_write); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL x0_wbvalid got %b want 1", wb_valid); end
        checks++; if (write_data !== 32'h12345678) begin errors++; $display("FAIL x0_wdata got %h want 12345678", write_data); end
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL x0_instret_before got %0d want 0", instret); end
        idle();
        tick();
        checks++; if (instret !== 64'd1) begin errors++; $display("FAIL x0_instret_after got %0d want 1", instret); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL bubble_wbvalid got %b want 0", wb_valid); end
        // A bubble sitting in WB must not count.
        tick();
        checks++; if (instret !== 64'd1) begin errors++; $display("FAIL bubble_instret got %0d want 1", instret); end
    endtask

    task automatic test_stall_flush();
        do_reset();
        drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b010, 2'd0, 32'h00000033, 32'h0, 32'h0, 32'h0);
        tick();
        stall = 1'b1;
        drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b010, 2'd0, 32'h00000055, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rd !== 5'd3 || write_data !== 32'h33 || reg_write !== 1'b1 || instret !== 64'd0) begin
                errors++;
                $display("FAIL stall_hold_%0d got rd=%0d wd=%h rw=%b instret=%0d want rd=3 wd=00000033 rw=1 instret=0",
                         i, rd, write_data, reg_write, instret);
            end
        end
        stall = 1'b0;
        idle();
        tick();
        checks++; if (instret !== 64'd1) begin errors++; $display("FAIL stall_release_instret got %0d want 1", instret); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL stall_release_wbvalid got %b want 0", wb_valid); end

        drive(1'b1, 1'b1, 5'd4, 2'b00, 3'b010, 2'd0, 32'h00000044, 32'h0, 32'h0, 32'h0);
        tick();
        checks++; if (reg_write !== 1'b1 || rd !== 5'd4) begin errors++; $display("FAIL preflush got rw=%b rd=%0d want rw=1 rd=4", reg_write, rd); end
        stall = 1'b1; flush = 1'b1;
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wbvalid got %b want 0", wb_valid); end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL flush_regwrite got %b want 0", reg_write); end
        checks++; if (instret !== 64'd2) begin errors++; $display("FAIL flush_instret got %0d want 2", instret); end
        stall = 1'b0; flush = 1'b0;
        idle();
        tick();
        checks++; if (instret !== 64'd2) begin errors++; $display("FAIL postflush_instret got %0d want 2", instret); end
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b1, 5'(i + 1), 2'b00, 3'b010, 2'd0, 32'(i), 32'h0, 32'h0, 32'h0);
            tick();
        end
        idle();
        tick();
        checks++; if (instret4 !== 4'd1) begin errors++; $display("FAIL wrap_instret4 got %0d want 1", instret4); end
        checks++; if (instret !== 64'd17) begin errors++; $display("FAIL b2b_instret64 got %0d want 17", instret); end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        idle();
        #2;
        test_reset();
        test_load_format();
        test_source_mux();
        test_x0_write();
        test_stall_flush();
        test_back_to_back_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
